// File: rtl/fpu_op_sequencer_pkg.sv
// Shared FPU class-flag definitions, canonical NaN and sequencer types.
package fpu_op_sequencer_pkg;

    localparam int unsigned ClsQnan      = 5;
    localparam int unsigned ClsSnan      = 4;
    localparam int unsigned ClsInf       = 3;
    localparam int unsigned ClsNormal    = 2;
    localparam int unsigned ClsSubnormal = 1;
    localparam int unsigned ClsZero      = 0;
    localparam int unsigned ClassW       = 6;

    localparam int unsigned ExpW  = 10;
    localparam int unsigned SigW  = 24;
    localparam int unsigned WdogW = 6;

    localparam logic [31:0] CanonicalQnan = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } seq_state_e;

    typedef struct packed {
        logic signed [ExpW-1:0] exp_val;
        logic [SigW-1:0]        sig;
        logic [ClassW-1:0]      cls;
    } unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpack into signed exponent, normalized significand
// and one-hot class flags.
module fp_unpack
    import fpu_op_sequencer_pkg::*;
(
    input  logic [31:0]            value,
    output logic signed [ExpW-1:0] exp_val,
    output logic [SigW-1:0]        sig,
    output logic [ClassW-1:0]      cls
);

    logic [7:0]  biased;
    logic [22:0] frac;
    logic [4:0]  shift;
    logic        found;
    logic        unused_sign;

    assign biased      = value[30:23];
    assign frac        = value[22:0];
    assign unused_sign = value[31];

    // Distance from the leading one of the fraction to the hidden-bit position.
    always_comb begin
        shift = 5'd0;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found && frac[i]) begin
                shift = 5'(23 - i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        exp_val = '0;
        sig     = '0;
        cls     = '0;
        if (biased == 8'hFF) begin
            exp_val = 10'sd128;
            sig     = {1'b1, frac};
            if (frac == '0) begin
                cls[ClsInf] = 1'b1;
            end else if (frac[22]) begin
                cls[ClsQnan] = 1'b1;
            end else begin
                cls[ClsSnan] = 1'b1;
            end
        end else if (biased == 8'h00) begin
            if (frac == '0) begin
                cls[ClsZero] = 1'b1;
            end else begin
                cls[ClsSubnormal] = 1'b1;
                sig               = {1'b0, frac} << shift;
                exp_val           = -10'sd126 - $signed({5'b0, shift});
            end
        end else begin
            cls[ClsNormal] = 1'b1;
            sig            = {1'b1, frac};
            exp_val        = $signed({2'b00, biased}) - 10'sd127;
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issue-side sequencer for the multi-cycle FDIV/FSQRT units: latches and unpacks
// operands, holds the unit enable until ready or watchdog timeout, returns the result.
module fpu_op_sequencer
    import fpu_op_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   op_i,
    input  logic [31:0]            rs1_i,
    input  logic [31:0]            rs2_i,
    input  logic [2:0]             rm_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [31:0]            result_o,
    output logic [1:0]             unitEnable_o,
    output logic signed [ExpW-1:0] rs1Exp_o,
    output logic signed [ExpW-1:0] rs2Exp_o,
    output logic [SigW-1:0]        rs1Sig_o,
    output logic [SigW-1:0]        rs2Sig_o,
    output logic [ClassW-1:0]      rs1Class_o,
    output logic [ClassW-1:0]      rs2Class_o,
    output logic [2:0]             rm_o,
    output logic [31:0]            raw1_o,
    output logic [31:0]            raw2_o,
    input  logic [1:0]             unitReady_i,
    input  logic [1:0][31:0]       unitResult_i
);

    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic             op_q;
    logic [31:0]      raw1_q, raw2_q;
    logic [2:0]       rm_q;
    unpacked_t        unp1_q, unp2_q;
    unpacked_t        unp1_d, unp2_d;
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic [31:0]      result_q;
    logic             error_q;

    logic             latch_op;
    logic             load_fields;
    logic             capture;
    logic [31:0]      capture_data;
    logic             capture_err;
    logic             sel_ready;
    logic [31:0]      sel_result;

    logic signed [ExpW-1:0] exp1, exp2;
    logic [SigW-1:0]        sig1, sig2;
    logic [ClassW-1:0]      cls1, cls2;

    fp_unpack u_unpack_rs1 (
        .value   (raw1_q),
        .exp_val (exp1),
        .sig     (sig1),
        .cls     (cls1)
    );

    fp_unpack u_unpack_rs2 (
        .value   (raw2_q),
        .exp_val (exp2),
        .sig     (sig2),
        .cls     (cls2)
    );

    assign unp1_d     = '{exp_val: exp1, sig: sig1, cls: cls1};
    assign unp2_d     = '{exp_val: exp2, sig: sig2, cls: cls2};
    assign sel_ready  = unitReady_i[op_q];
    assign sel_result = unitResult_i[op_q];

    always_comb begin
        state_d      = state_q;
        latch_op     = 1'b0;
        load_fields  = 1'b0;
        capture      = 1'b0;
        capture_data = result_q;
        capture_err  = 1'b0;
        wdog_d       = '0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    latch_op = 1'b1;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                load_fields = 1'b1;
                state_d     = StRun;
            end
            StRun: begin
                wdog_d = wdog_q + 1'b1;
                // A genuine unit result wins over a watchdog expiry on the same edge.
                if (sel_ready) begin
                    capture      = 1'b1;
                    capture_data = sel_result;
                    wdog_d       = '0;
                    state_d      = StDone;
                end else if (wdog_q == WdogLast) begin
                    capture      = 1'b1;
                    capture_data = CanonicalQnan;
                    capture_err  = 1'b1;
                    wdog_d       = '0;
                    state_d      = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            op_q     <= 1'b0;
            raw1_q   <= '0;
            raw2_q   <= '0;
            rm_q     <= '0;
            unp1_q   <= '0;
            unp2_q   <= '0;
            wdog_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            if (latch_op) begin
                op_q   <= op_i;
                raw1_q <= rs1_i;
                raw2_q <= rs2_i;
                rm_q   <= rm_i;
            end
            if (load_fields) begin
                unp1_q <= unp1_d;
                unp2_q <= unp2_d;
            end
            if (capture) begin
                result_q <= capture_data;
                error_q  <= capture_err;
            end
        end
    end

    always_comb begin
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);
        unitEnable_o = 2'b00;
        if (state_q == StRun) begin
            unitEnable_o = op_q ? 2'b10 : 2'b01;
        end
    end

    assign error_o    = error_q;
    assign result_o   = result_q;
    assign rs1Exp_o   = unp1_q.exp_val;
    assign rs2Exp_o   = unp2_q.exp_val;
    assign rs1Sig_o   = unp1_q.sig;
    assign rs2Sig_o   = unp2_q.sig;
    assign rs1Class_o = unp1_q.cls;
    assign rs2Class_o = unp2_q.cls;
    assign rm_o       = rm_q;
    assign raw1_o     = raw1_q;
    assign raw2_o     = raw2_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench: table vectors, hand sequences and randomized operations
// against a behavioural unpack/timing model.
module tb_fpu_op_sequencer;

    localparam int TO = 63;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              start_i;
    logic              op_i;
    logic [31:0]       rs1_i, rs2_i;
    logic [2:0]        rm_i;
    logic              busy, done, error;
    logic [31:0]       result;
    logic [1:0]        unit_en;
    logic signed [9:0] rs1_exp, rs2_exp;
    logic [23:0]       rs1_sig, rs2_sig;
    logic [5:0]        rs1_cls, rs2_cls;
    logic [2:0]        rm_out;
    logic [31:0]       raw1, raw2;
    logic [1:0]        unit_ready;
    logic [1:0][31:0]  unit_result;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    fpu_op_sequencer #(.TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .op_i         (op_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rm_i         (rm_i),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .result_o     (result),
        .unitEnable_o (unit_en),
        .rs1Exp_o     (rs1_exp),
        .rs2Exp_o     (rs2_exp),
        .rs1Sig_o     (rs1_sig),
        .rs2Sig_o     (rs2_sig),
        .rs1Class_o   (rs1_cls),
        .rs2Class_o   (rs2_cls),
        .rm_o         (rm_out),
        .raw1_o       (raw1),
        .raw2_o       (raw2),
        .unitReady_i  (unit_ready),
        .unitResult_i (unit_result)
    );

    typedef struct {
        logic        op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  rm;
        int          rdy;      // edge index of the selected ready, 0 = never
        logic [31:0] ures;
        int          stray;    // edge index of a ready pulse on the other unit
        int          restart;  // edge index of a start_i pulse while busy
        logic [31:0] eres;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [31:0] in;
        int          e;
        logic [23:0] s;
        logic [5:0]  c;
    } unp_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endtask

    // Reference unpack from the IEEE-754 value rules, using integer arithmetic.
    function automatic void unpack_model(input logic [31:0] x, output int e, output int s,
                                         output logic [5:0] c);
        int bexp;
        int f;
        bexp = int'(x[30:23]);
        f    = int'(x[22:0]);
        if (bexp == 255) begin
            e = 128;
            s = f + (1 << 23);
            if (f == 0) c = 6'b001000;
            else if (x[22]) c = 6'b100000;
            else c = 6'b010000;
        end else if (bexp == 0 && f == 0) begin
            e = 0;
            s = 0;
            c = 6'b000001;
        end else if (bexp == 0) begin
            s = f;
            e = -126;
            while (s < (1 << 23)) begin
                s = s * 2;
                e = e - 1;
            end
            c = 6'b000010;
        end else begin
            e = bexp - 127;
            s = f + (1 << 23);
            c = 6'b000100;
        end
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[22:0] = v[22:0] >> $urandom_range(0, 23);
            default: ;
        endcase
        return v;
    endfunction

    // Issue one operation starting just after an edge in IDLE; T0 is the next edge.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rm, input int rdy, input logic [31:0] ures,
                          input int stray, input int restart, input logic [31:0] eres,
                          input logic eerr);
        int          e;
        int          s;
        logic [5:0]  c;
        int          exp_edge;
        int          done_k;
        logic        en_bad;
        logic [1:0]  en_want;
        exp_edge = (rdy != 0) ? rdy : 1 + TO;
        en_want  = op ? 2'b10 : 2'b01;
        done_k   = -1;
        en_bad   = 1'b0;
        op_i     = op;
        rs1_i    = a;
        rs2_i    = b;
        rm_i     = rm;
        unit_result[op]  = ures;
        unit_result[!op] = ~ures;
        start_i  = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        rs1_i   = ~a;
        rs2_i   = ~b;
        rm_i    = ~rm;
        op_i    = ~op;
        chk("busy_in_load", {31'b0, busy}, 32'd1);
        chk("enable_in_load", {30'b0, unit_en}, 32'd0);
        for (int k = 1; k <= TO + 8 && done_k < 0; k++) begin
            unit_ready = 2'b00;
            if (k == rdy) unit_ready[op] = 1'b1;
            if (k == stray) unit_ready[!op] = 1'b1;
            start_i = (k == restart);
            @(posedge clk_i); #1;
            if (k == 1) begin
                chk("enable_run", {30'b0, unit_en}, {30'b0, en_want});
                unpack_model(a, e, s, c);
                chk("rs1_exp", 32'(rs1_exp), 32'(e));
                chk("rs1_sig", {8'b0, rs1_sig}, 32'(s));
                chk("rs1_class", {26'b0, rs1_cls}, {26'b0, c});
                unpack_model(b, e, s, c);
                chk("rs2_exp", 32'(rs2_exp), 32'(e));
                chk("rs2_sig", {8'b0, rs2_sig}, 32'(s));
                chk("rs2_class", {26'b0, rs2_cls}, {26'b0, c});
                chk("rm_latched", {29'b0, rm_out}, {29'b0, rm});
                chk("raw1_latched", raw1, a);
                chk("raw2_latched", raw2, b);
            end
            if (done) done_k = k;
            else if (unit_en !== en_want) en_bad = 1'b1;
        end
        unit_ready = 2'b00;
        start_i    = 1'b0;
        chk("done_edge", 32'(done_k), 32'(exp_edge));
        chk("enable_held_in_run", {31'b0, en_bad}, 32'd0);
        chk("result", result, eres);
        chk("error", {31'b0, error}, {31'b0, eerr});
        chk("enable_in_done", {30'b0, unit_en}, 32'd0);
        chk("raw1_kept", raw1, a);
        @(posedge clk_i); #1;
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("result_hold", result, eres);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_error"}, {31'b0, error}, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_enable"}, {30'b0, unit_en}, 32'd0);
        chk({tag, "_rs1_exp"}, 32'(rs1_exp), 32'd0);
        chk({tag, "_rs1_sig"}, {8'b0, rs1_sig}, 32'd0);
        chk({tag, "_rs1_class"}, {26'b0, rs1_cls}, 32'd0);
        chk({tag, "_raw1"}, raw1, 32'd0);
        chk({tag, "_rm"}, {29'b0, rm_out}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running, want finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        vec_t     tv[6];
        unp_vec_t uv[7];
        vec_t     r;

        tv[0] = '{1'b0, 32'h40C00000, 32'h40000000, 3'b000, 30, 32'h40400000, 0, 0,
                  32'h40400000, 1'b0};
        tv[1] = '{1'b0, 32'h00000001, 32'h3F800000, 3'b001, 4, 32'h12345678, 0, 0,
                  32'h12345678, 1'b0};
        tv[2] = '{1'b1, 32'h7F800001, 32'h00000000, 3'b010, 12, 32'h3FB504F3, 5, 0,
                  32'h3FB504F3, 1'b0};
        tv[3] = '{1'b0, 32'h3F800000, 32'h00000000, 3'b011, 0, 32'h11111111, 0, 0,
                  32'h7FC00000, 1'b1};
        tv[4] = '{1'b1, 32'h40800000, 32'hBF800000, 3'b100, 20, 32'hC0000000, 0, 5,
                  32'hC0000000, 1'b0};
        tv[5] = '{1'b0, 32'h80000000, 32'h7F800000, 3'b111, 3, 32'h00000000, 3, 0,
                  32'h00000000, 1'b0};

        uv[0] = '{32'h00000001, -149, 24'h800000, 6'b000010};
        uv[1] = '{32'h3F800000, 0, 24'h800000, 6'b000100};
        uv[2] = '{32'h7F800001, 128, 24'h800001, 6'b010000};
        uv[3] = '{32'h80000000, 0, 24'h000000, 6'b000001};
        uv[4] = '{32'h7FC00000, 128, 24'hC00000, 6'b100000};
        uv[5] = '{32'hFF800000, 128, 24'h800000, 6'b001000};
        uv[6] = '{32'h00400000, -127, 24'h800000, 6'b000010};

        reset_i     = 1'b1;
        start_i     = 1'b0;
        op_i        = 1'b0;
        rs1_i       = '0;
        rs2_i       = '0;
        rm_i        = '0;
        unit_ready  = '0;
        unit_result = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_state("por");
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(tv[i].op, tv[i].rs1, tv[i].rs2, tv[i].rm, tv[i].rdy, tv[i].ures,
                   tv[i].stray, tv[i].restart, tv[i].eres, tv[i].eerr);
        end

        for (int i = 0; i < 7; i++) begin
            run_op(i[0], uv[i].in, 32'h3F800000, 3'b000, 3, 32'hA5A50000 + 32'(i), 0, 0,
                   32'hA5A50000 + 32'(i), 1'b0);
            chk("sweep_exp", 32'(rs1_exp), 32'(uv[i].e));
            chk("sweep_sig", {8'b0, rs1_sig}, {8'b0, uv[i].s});
            chk("sweep_class", {26'b0, rs1_cls}, {26'b0, uv[i].c});
        end

        // Reset at T10 while the unit is still running, then a normal restart at T12.
        op_i    = 1'b0;
        rs1_i   = 32'h40C00000;
        rs2_i   = 32'h40000000;
        rm_i    = 3'b101;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        chk_reset_state("mid_run_reset");
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        run_op(1'b0, 32'h40C00000, 32'h40000000, 3'b000, 30, 32'h40400000, 0, 0,
               32'h40400000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            r.op      = 1'($urandom);
            r.rs1     = rnd_fp();
            r.rs2     = rnd_fp();
            r.rm      = 3'($urandom);
            r.rdy     = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(3, 60));
            r.ures    = $urandom;
            r.stray   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 60));
            r.restart = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 60));
            r.eres    = (r.rdy != 0) ? r.ures : 32'h7FC00000;
            r.eerr    = (r.rdy == 0);
            run_op(r.op, r.rs1, r.rs2, r.rm, r.rdy, r.ures, r.stray, r.restart,
                   r.eres, r.eerr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
